// File: rtl/effect_chain_sequencer.sv
// effect_chain_sequencer
//
// Upstream scheduler for the audio effect stages. Takes one codec sample per
// frame and walks it through every enabled effect slot in index order using the
// my_turn/done handshake. Each effect's result becomes the input of the next
// enabled slot, and the final value goes out on sample_out. Disabled slots are
// skipped. A hung effect is abandoned after TIMEOUT_CYCLES and flagged.
//
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   sample_in(_valid) - codec sample plus a one-cycle strobe
//   sample_out(_valid)- processed sample plus a one-cycle strobe
//   effect_cs         - per-slot enable (0 = bypass)
//   effect_my_turn    - one-hot turn grant to the effects (level)
//   effect_data_in    - shared sample bus to all effects (always cur_sample)
//   effect_done       - per-slot done from the effects
//   effect_data_out   - flattened per-slot results, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//   busy              - high whenever the sequencer is not idle
//   overrun           - sticky: a sample arrived while busy and was dropped
//   timeout_err       - sticky per-slot timeout flags
//   err_clear         - clears overrun and timeout_err (a same-cycle set wins)
module effect_chain_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_EFFECTS    = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             sample_in,
  input  logic                              sample_in_valid,
  output logic [DATA_WIDTH-1:0]             sample_out,
  output logic                              sample_out_valid,
  input  logic [NUM_EFFECTS-1:0]            effect_cs,
  output logic [NUM_EFFECTS-1:0]            effect_my_turn,
  output logic [DATA_WIDTH-1:0]             effect_data_in,
  input  logic [NUM_EFFECTS-1:0]            effect_done,
  input  logic [NUM_EFFECTS*DATA_WIDTH-1:0] effect_data_out,
  output logic                              busy,
  output logic                              overrun,
  output logic [NUM_EFFECTS-1:0]            timeout_err,
  input  logic                              err_clear
);

  // idx must reach NUM_EFFECTS, which marks "past the last slot"
  localparam int IDX_W = $clog2(NUM_EFFECTS + 1);
  localparam logic [IDX_W-1:0] END_IDX = IDX_W'(NUM_EFFECTS);
  localparam logic [15:0] TIMER_MAX = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    WAIT_DONE,
    RELEASE
  } state_t;

  state_t                  state, state_next;
  logic [IDX_W-1:0]        idx, idx_next;
  logic [15:0]             timer, timer_next;
  logic [DATA_WIDTH-1:0]   cur_sample, cur_sample_next;
  logic [DATA_WIDTH-1:0]   sample_out_next;
  logic                    sample_out_valid_next;
  logic                    overrun_next;
  logic [NUM_EFFECTS-1:0]  my_turn_next, timeout_err_next;
  logic [NUM_EFFECTS-1:0]  slot_onehot;
  logic [DATA_WIDTH-1:0]   slot_data;
  logic                    slot_cs, slot_done, timer_expired;

  assign busy           = (state != IDLE);
  assign effect_data_in = cur_sample;
  assign timer_expired  = (timer == TIMER_MAX);

  // Select the current slot's enable, done and result. When idx has run past
  // the last slot nothing matches, so all selects read as zero.
  always_comb begin
    slot_onehot = '0;
    slot_data   = '0;
    slot_cs     = 1'b0;
    slot_done   = 1'b0;
    for (int i = 0; i < NUM_EFFECTS; i++) begin
      if (idx == IDX_W'(i)) begin
        slot_onehot[i] = 1'b1;
        slot_data      = effect_data_out[i*DATA_WIDTH +: DATA_WIDTH];
        slot_cs        = effect_cs[i];
        slot_done      = effect_done[i];
      end
    end
  end

  // Next-state and next-output logic. Sticky flags are cleared first and then
  // set, so a set event in the same cycle as err_clear survives.
  always_comb begin
    state_next            = state;
    idx_next              = idx;
    timer_next            = timer;
    cur_sample_next       = cur_sample;
    my_turn_next          = effect_my_turn;
    sample_out_next       = sample_out;
    sample_out_valid_next = 1'b0;
    overrun_next          = err_clear ? 1'b0 : overrun;
    timeout_err_next      = err_clear ? '0 : timeout_err;

    if (sample_in_valid && (state != IDLE))
      overrun_next = 1'b1;

    case (state)
      IDLE: begin
        if (sample_in_valid) begin
          cur_sample_next = sample_in;
          idx_next        = '0;
          state_next      = SELECT;
        end
      end
      SELECT: begin
        if (idx == END_IDX) begin
          sample_out_next       = cur_sample;
          sample_out_valid_next = 1'b1;
          state_next            = IDLE;
        end else if (!slot_cs) begin
          idx_next = idx + IDX_W'(1);
        end else begin
          my_turn_next = slot_onehot;
          timer_next   = '0;
          state_next   = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        timer_next = timer + 16'd1;
        // done is checked first so a done arriving on the last allowed cycle
        // is taken as a good result rather than a timeout
        if (slot_done) begin
          cur_sample_next = slot_data;
          my_turn_next    = '0;
          timer_next      = '0;
          state_next      = RELEASE;
        end else if (timer_expired) begin
          my_turn_next     = '0;
          timeout_err_next = timeout_err_next | slot_onehot;
          timer_next       = '0;
          state_next       = RELEASE;
        end
      end
      RELEASE: begin
        // effects may hold done for a cycle or two after my_turn drops; wait
        // for it to fall, but never forever
        timer_next = timer + 16'd1;
        if (!slot_done || timer_expired) begin
          idx_next   = idx + IDX_W'(1);
          timer_next = '0;
          state_next = SELECT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx              <= '0;
      timer            <= '0;
      cur_sample       <= '0;
      effect_my_turn   <= '0;
      sample_out       <= '0;
      sample_out_valid <= 1'b0;
      overrun          <= 1'b0;
      timeout_err      <= '0;
    end else begin
      idx              <= idx_next;
      timer            <= timer_next;
      cur_sample       <= cur_sample_next;
      effect_my_turn   <= my_turn_next;
      sample_out       <= sample_out_next;
      sample_out_valid <= sample_out_valid_next;
      overrun          <= overrun_next;
      timeout_err      <= timeout_err_next;
    end
  end

endmodule
